// File: rtl/average_filter.sv
// Boxcar moving average over the last 2**LOG2_TAPS accepted samples; 2-clock latency.
// No backpressure: one sample per clock when i_ce is high.
module average_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int LOG2_TAPS  = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_ce,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         o_ce
);

  localparam int N  = 1 << LOG2_TAPS;
  localparam int SW = DATA_WIDTH + LOG2_TAPS;

  logic signed [DATA_WIDTH-1:0] hist [N];
  logic signed [SW-1:0]         sum;
  logic signed [SW-1:0]         x_ext;
  logic signed [SW-1:0]         old_ext;
  logic signed [SW-1:0]         avg_full;
  logic                         primed;
  logic                         s1_vld;

  assign x_ext    = SW'(data_in);
  assign old_ext  = SW'(hist[N-1]);
  // Arithmetic shift floors toward -inf; the mean always fits DATA_WIDTH.
  assign avg_full = sum >>> LOG2_TAPS;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) hist[i] <= '0;
      sum      <= '0;
      primed   <= 1'b0;
      s1_vld   <= 1'b0;
      data_out <= '0;
      o_ce     <= 1'b0;
    end else begin
      s1_vld <= i_ce;
      o_ce   <= s1_vld;
      if (s1_vld) data_out <= avg_full[DATA_WIDTH-1:0];
      if (i_ce) begin
        primed <= 1'b1;
        if (!primed) begin
          // First sample after reset fills the whole window so the first mean equals it.
          for (int i = 0; i < N; i++) hist[i] <= data_in;
          sum <= x_ext <<< LOG2_TAPS;
        end else begin
          hist[0] <= data_in;
          for (int i = 1; i < N; i++) hist[i] <= hist[i-1];
          sum <= sum + x_ext - old_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_average_filter.sv
// Bench for average_filter: window-queue model checked every cycle plus literal output sequences.
module tb_average_filter;

  localparam int DW = 8;
  localparam int L2 = 1;
  localparam int N  = 1 << L2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 i_ce = 1'b0;
  logic signed [DW-1:0] data_in = '0;
  logic signed [DW-1:0] data_out;
  logic                 o_ce;

  int errors = 0;
  int checks = 0;

  int  win[$];
  int  got[$];
  int  want[$];
  bit  armed = 1'b0;
  bit  pend_vld = 1'b0;
  int  pend_val = 0;
  bit  exp_vld = 1'b0;
  int  exp_out = 0;

  average_filter #(.DATA_WIDTH(DW), .LOG2_TAPS(L2)) dut (
    .clk(clk), .reset(reset), .i_ce(i_ce), .data_in(data_in),
    .data_out(data_out), .o_ce(o_ce)
  );

  always #5 clk = ~clk;

  function automatic int floor_mean(input int s);
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: window of the last N accepted samples, mean appears two edges later.
  always @(posedge clk) begin
    if (!reset) begin
      win.delete();
      pend_vld = 1'b0;
      exp_vld  = 1'b0;
      exp_out  = 0;
      armed    = 1'b1;
    end else begin
      if (pend_vld) exp_out = pend_val;
      exp_vld  = pend_vld;
      pend_vld = i_ce;
      if (i_ce) begin
        int s;
        if (win.size() == 0) begin
          for (int i = 0; i < N; i++) win.push_back(int'(data_in));
        end else begin
          win.push_back(int'(data_in));
          void'(win.pop_front());
        end
        s = 0;
        foreach (win[i]) s += win[i];
        pend_val = floor_mean(s);
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("o_ce_model", int'(o_ce), int'(exp_vld));
      check("data_out_model", int'(data_out), exp_out);
      if (o_ce) got.push_back(int'(data_out));
    end
  end

  task automatic send(input int v);
    @(negedge clk);
    i_ce    = 1'b1;
    data_in = DW'(v);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_ce = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    i_ce  = 1'b0;
    @(negedge clk);
    check("reset_data_out", int'(data_out), 0);
    check("reset_o_ce", int'(o_ce), 0);
    reset = 1'b1;
  endtask

  task automatic check_got(input string name, input int base);
    check({name, "_count"}, got.size() - base, want.size());
    foreach (want[i]) begin
      if (base + i < got.size()) check(name, got[base + i], want[i]);
      else check(name, 0, want[i]);
    end
  endtask

  initial begin
    int base;

    // 1: priming and latency
    do_reset();
    base = got.size();
    send(10);
    @(negedge clk);
    i_ce = 1'b0;
    check("lat_edge1_o_ce", int'(o_ce), 0);
    @(negedge clk);
    check("lat_edge2_o_ce", int'(o_ce), 1);
    check("lat_edge2_data", int'(data_out), 10);
    idle(3);

    // 2: continuous stream
    do_reset();
    base = got.size();
    send(10); send(-20); send(30); send(-40); send(50); send(0); send(100);
    idle(4);
    want = '{10, -5, 5, -5, 5, 25, 50};
    check_got("stream", base);

    // 3: floor rounding
    do_reset();
    base = got.size();
    send(100); send(-127);
    idle(4);
    want = '{100, -14};
    check_got("floor", base);

    // 4: cancel and extremes
    do_reset();
    base = got.size();
    send(-127); send(127); send(127); send(-60);
    idle(4);
    want = '{-127, 0, 127, 33};
    check_got("cancel", base);
    do_reset();
    base = got.size();
    send(-128); send(-128);
    idle(4);
    want = '{-128, -128};
    check_got("min", base);
    do_reset();
    base = got.size();
    send(127); send(127);
    idle(4);
    want = '{127, 127};
    check_got("max", base);

    // 5: gapped input, output holds between pulses
    do_reset();
    base = got.size();
    send(8); idle(3);
    check("gap_pulse", int'(o_ce), 0);
    check("gap_hold", int'(data_out), 8);
    send(-3); idle(3);
    send(6); idle(4);
    want = '{8, 2, 1};
    check_got("gaps", base);

    // 6: reset mid-stream overrides i_ce and re-primes
    do_reset();
    base = got.size();
    send(50); send(50); send(50);
    @(negedge clk);
    reset   = 1'b0;
    i_ce    = 1'b1;
    data_in = DW'(77);
    @(negedge clk);
    check("midrst_data_out", int'(data_out), 0);
    check("midrst_o_ce", int'(o_ce), 0);
    reset   = 1'b1;
    i_ce    = 1'b1;
    data_in = DW'(40);
    send(20);
    idle(4);
    want = '{50, 50, 40, 30};
    check_got("midrst", base);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
